// File: rtl/median_pkg.sv
// Shared defaults and FSM state encoding for the median window controller.
package median_pkg;

   localparam int unsigned DEF_W        = 11;
   localparam int unsigned DEF_KSIZE    = 5;
   localparam int unsigned DEF_MIN_LINE = 16;
   localparam int unsigned DEF_MAX_LINE = 2047;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      MEASURE = 2'd2,
      LOCKED  = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Rising-edge detector; the history flop resets high so a level already
// asserted at reset release is not mistaken for an edge.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise_c
);

   logic din_q;
   logic din_d;

   always_comb begin
      din_d = din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         din_q <= 1'b1;
      end else begin
         din_q <= din_d;
      end
   end

   assign rise_c = din & ~din_q;

endmodule

// File: rtl/median_window_ctrl.sv
// Measures the incoming line length, programs the line-delay depth and tracks
// pixel column/row so the 5x5 median filter can blank its border pixels.
module median_window_ctrl
   import median_pkg::*;
#(
   parameter int unsigned W        = DEF_W,
   parameter int unsigned KSIZE    = DEF_KSIZE,
   parameter int unsigned MIN_LINE = DEF_MIN_LINE,
   parameter int unsigned MAX_LINE = DEF_MAX_LINE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         de,
   input  logic         hsync,
   input  logic         vsync,
   output logic [W-1:0] h_size,
   output logic         h_size_valid,
   output logic         locked,
   output logic         len_err,
   output logic [W-1:0] col,
   output logic [W-1:0] row,
   output logic         context_valid
);

   localparam int unsigned BORDER = KSIZE - 1;

   logic hs_rise_c;
   logic vs_rise_c;
   logic below_max_c;
   logic len_ok_c;

   ctrl_state_t  state_q,         state_d;
   logic [W-1:0] lc_q,            lc_d;
   logic [W-1:0] l_ref_q,         l_ref_d;
   logic [W-1:0] h_size_q,        h_size_d;
   logic         h_size_valid_q,  h_size_valid_d;
   logic         locked_q,        locked_d;
   logic         len_err_q,       len_err_d;
   logic [W-1:0] col_q,           col_d;
   logic [W-1:0] row_q,           row_d;
   logic         line_had_de_q,   line_had_de_d;
   logic         context_valid_q, context_valid_d;

   sync_edge_det u_hs_edge (
      .clk    (clk),
      .rst    (rst),
      .din    (hsync),
      .rise_c (hs_rise_c)
   );

   sync_edge_det u_vs_edge (
      .clk    (clk),
      .rst    (rst),
      .din    (vsync),
      .rise_c (vs_rise_c)
   );

   // Upper bound only matters when it is below the counter's own saturation point.
   if (MAX_LINE >= ((32'd1 << W) - 32'd1)) begin : g_max_full
      assign below_max_c = 1'b1;
   end else begin : g_max_lim
      assign below_max_c = (lc_q <= W'(MAX_LINE));
   end

   assign len_ok_c = (lc_q >= W'(MIN_LINE)) && below_max_c && (lc_q != '1);

   always_comb begin
      state_d         = state_q;
      lc_d            = lc_q;
      l_ref_d         = l_ref_q;
      h_size_d        = h_size_q;
      h_size_valid_d  = h_size_valid_q;
      len_err_d       = 1'b0;
      col_d           = col_q;
      row_d           = row_q;
      line_had_de_d   = line_had_de_q | de;

      // Line-length counter: the value seen on an hsync edge is the length of the line just ended.
      if (hs_rise_c) begin
         lc_d = W'(1);
      end else if (lc_q != '1) begin
         lc_d = lc_q + W'(1);
      end

      case (state_q)
         IDLE: begin
            if (vs_rise_c) begin
               state_d = SYNC;
            end
         end
         SYNC: begin
            if (hs_rise_c) begin
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (hs_rise_c && len_ok_c) begin
               state_d        = LOCKED;
               l_ref_d        = lc_q;
               h_size_d       = lc_q - W'(KSIZE);
               h_size_valid_d = 1'b1;
            end
         end
         LOCKED: begin
            if (hs_rise_c && (lc_q != l_ref_q)) begin
               state_d        = MEASURE;
               len_err_d      = 1'b1;
               h_size_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (!enable) begin
         state_d        = IDLE;
         h_size_valid_d = 1'b0;
         len_err_d      = 1'b0;
      end

      if (hs_rise_c) begin
         col_d = '0;
      end else if (de && (col_q != '1)) begin
         col_d = col_q + W'(1);
      end

      // A row only advances once the line it closes actually carried pixels.
      if (hs_rise_c) begin
         if (line_had_de_q && (row_q != '1)) begin
            row_d = row_q + W'(1);
         end
         line_had_de_d = de;
      end
      if (vs_rise_c) begin
         row_d         = '0;
         line_had_de_d = 1'b0;
      end

      locked_d        = (state_d == LOCKED);
      context_valid_d = (state_d == LOCKED) && de &&
                        (col_q >= W'(BORDER)) && (row_q >= W'(BORDER));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         lc_q            <= '0;
         l_ref_q         <= '0;
         h_size_q        <= '0;
         h_size_valid_q  <= 1'b0;
         locked_q        <= 1'b0;
         len_err_q       <= 1'b0;
         col_q           <= '0;
         row_q           <= '0;
         line_had_de_q   <= 1'b0;
         context_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         lc_q            <= lc_d;
         l_ref_q         <= l_ref_d;
         h_size_q        <= h_size_d;
         h_size_valid_q  <= h_size_valid_d;
         locked_q        <= locked_d;
         len_err_q       <= len_err_d;
         col_q           <= col_d;
         row_q           <= row_d;
         line_had_de_q   <= line_had_de_d;
         context_valid_q <= context_valid_d;
      end
   end

   assign h_size        = h_size_q;
   assign h_size_valid  = h_size_valid_q;
   assign locked        = locked_q;
   assign len_err       = len_err_q;
   assign col           = col_q;
   assign row           = row_q;
   assign context_valid = context_valid_q;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Scoreboard bench for median_window_ctrl: stimulus queues expected status
// changes and context pixels, a monitor compares whenever the DUT shows them.
module tb_median_window_ctrl;
   import median_pkg::*;

   localparam int unsigned W = DEF_W;

   typedef struct packed {
      logic         len_err;
      logic         locked;
      logic         hv;
      logic [W-1:0] h_size;
   } status_t;

   typedef struct packed {
      logic [W-1:0] row;
      logic [W-1:0] col;
   } pix_t;

   logic         clk    = 1'b0;
   logic         rst    = 1'b1;
   logic         enable = 1'b1;
   logic         de     = 1'b0;
   logic         hsync  = 1'b1;
   logic         vsync  = 1'b1;
   logic [W-1:0] h_size;
   logic         h_size_valid;
   logic         locked;
   logic         len_err;
   logic [W-1:0] col;
   logic [W-1:0] row;
   logic         context_valid;

   status_t st_q[$];
   pix_t    pix_q[$];
   int      checks   = 0;
   int      passes   = 0;
   int      cv_count = 0;
   int      pix_line = 0;

   always #5 clk = ~clk;

   median_window_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .de            (de),
      .hsync         (hsync),
      .vsync         (vsync),
      .h_size        (h_size),
      .h_size_valid  (h_size_valid),
      .locked        (locked),
      .len_err       (len_err),
      .col           (col),
      .row           (row),
      .context_valid (context_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic status_t mk_st(input logic e, input logic l, input logic v, input int h);
      status_t s;
      s.len_err = e;
      s.locked  = l;
      s.hv      = v;
      s.h_size  = W'(h);
      return s;
   endfunction

   // Monitor: status changes and context_valid pulses are the DUT's output events.
   initial begin
      status_t prev, cur, exp_s;
      pix_t    last_pix, exp_p;
      prev     = '0;
      last_pix = '0;
      forever begin
         @(negedge clk);
         cur = {len_err, locked, h_size_valid, h_size};
         if (rst) begin
            prev = cur;
         end else begin
            if (cur !== prev) begin
               if (st_q.size() == 0) begin
                  checks++;
                  $display("FAIL status_unexpected: got 0x%0h expected no change at %0t",
                           32'(cur), $time);
               end else begin
                  exp_s = st_q.pop_front();
                  check("status", 32'(cur), 32'(exp_s));
               end
               prev = cur;
            end
            if (context_valid === 1'b1) begin
               cv_count++;
               if (pix_q.size() == 0) begin
                  checks++;
                  $display("FAIL cv_unexpected: got row %0d col %0d expected none at %0t",
                           last_pix.row, last_pix.col, $time);
               end else begin
                  exp_p = pix_q.pop_front();
                  check("cv_pos", 32'(last_pix), 32'(exp_p));
               end
            end
         end
         last_pix = {row, col};
      end
   end

   task automatic cyc(input logic h, input logic v, input logic d);
      hsync = h;
      vsync = v;
      de    = d;
      @(posedge clk);
      #1;
   endtask

   // One line: hsync pulse at cycle 0, optional vsync at cycle 2, pixels from cycle 8.
   task automatic line(input int len, input int npix, input bit vs, input bit lk, input int drop_at);
      for (int i = 0; i < len; i++) begin
         logic d;
         d = (i >= 8) && (i < 8 + npix);
         if (drop_at >= 0 && i == drop_at) enable = 1'b0;
         if (d && lk && (drop_at < 0 || i < drop_at) && pix_line >= 4 && (i - 8) >= 4)
            pix_q.push_back({W'(pix_line), W'(i - 8)});
         cyc(i == 0, vs && (i == 2), d);
      end
      if (vs) pix_line = 0;
      else if (npix > 0) pix_line++;
   endtask

   initial begin
      int cv0;

      // 1: reset with syncs held high, no edges after release
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0);
      check("rst_h_size", 32'(h_size), 32'd0);
      check("rst_h_size_valid", 32'(h_size_valid), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_len_err", 32'(len_err), 32'd0);
      check("rst_col", 32'(col), 32'd0);
      check("rst_row", 32'(row), 32'd0);
      check("rst_cv", 32'(context_valid), 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);

      // 2: vsync then two hsync edges lock at L=83
      line(83, 0, 1'b1, 1'b0, -1);
      line(83, 64, 1'b0, 1'b0, -1);
      st_q.push_back(mk_st(1'b0, 1'b1, 1'b1, 78));
      line(83, 64, 1'b0, 1'b1, -1);

      // 3: length change to 84 -> error pulse, then relock with h_size 79
      line(83, 64, 1'b0, 1'b1, -1);
      line(84, 64, 1'b0, 1'b1, -1);
      st_q.push_back(mk_st(1'b1, 1'b0, 1'b0, 78));
      st_q.push_back(mk_st(1'b0, 1'b0, 1'b0, 78));
      line(84, 64, 1'b0, 1'b0, -1);
      st_q.push_back(mk_st(1'b0, 1'b1, 1'b1, 79));
      line(84, 64, 1'b0, 1'b1, -1);
      line(84, 64, 1'b0, 1'b1, -1);
      check("t3_h_size", 32'(h_size), 32'd79);

      // 4: full 64x64 locked frame
      line(84, 0, 1'b1, 1'b1, -1);
      cv0 = cv_count;
      for (int r = 0; r < 64; r++) line(84, 64, 1'b0, 1'b1, -1);
      check("t4_cv_count", 32'(cv_count - cv0), 32'd3600);

      // 6: enable dropped mid-line while locked
      st_q.push_back(mk_st(1'b0, 1'b0, 1'b0, 79));
      line(84, 64, 1'b0, 1'b1, 20);
      check("t6_h_size_held", 32'(h_size), 32'd79);
      check("t6_locked", 32'(locked), 32'd0);
      check("t6_cv", 32'(context_valid), 32'd0);
      enable = 1'b1;
      line(84, 0, 1'b0, 1'b0, -1);
      line(84, 0, 1'b0, 1'b0, -1);
      check("t6_no_relock_wo_vsync", 32'(locked), 32'd0);
      line(84, 0, 1'b1, 1'b0, -1);
      line(84, 0, 1'b0, 1'b0, -1);
      st_q.push_back(mk_st(1'b0, 1'b1, 1'b1, 79));
      line(84, 0, 1'b0, 1'b0, -1);
      line(84, 0, 1'b0, 1'b0, -1);
      check("t6_relocked", 32'(locked), 32'd1);

      // 5: short lines and saturated lines never lock
      line(10, 0, 1'b0, 1'b0, -1);
      st_q.push_back(mk_st(1'b1, 1'b0, 1'b0, 79));
      st_q.push_back(mk_st(1'b0, 1'b0, 1'b0, 79));
      line(10, 0, 1'b0, 1'b0, -1);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
      enable = 1'b1;
      line(10, 0, 1'b1, 1'b0, -1);
      for (int i = 0; i < 6; i++) line(10, 0, 1'b0, 1'b0, -1);
      check("t5_short_hv", 32'(h_size_valid), 32'd0);
      for (int i = 0; i < 3; i++) line(3000, 0, 1'b0, 1'b0, -1);
      line(20, 0, 1'b0, 1'b0, -1);
      check("t5_sat_hv", 32'(h_size_valid), 32'd0);
      check("t5_sat_locked", 32'(locked), 32'd0);
      check("t5_h_size_held", 32'(h_size), 32'd79);

      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
      check("status_queue_drained", 32'(st_q.size()), 32'd0);
      check("pixel_queue_drained", 32'(pix_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
